// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - command codes, response bytes and FSM states for uart_loader
package uart_loader_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_WSUM,
        S_RREQ,
        S_RLAT,
        S_RSEND,
        S_RSUM,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_loader_timeout.sv
// rtl/uart_loader_timeout.sv - inter-byte watchdog: reloads on clear or when disabled, expires at zero
module uart_loader_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= LOAD;
        end else if (clear || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART command responder: framed W/R/G commands to a ram32 port, holds CPU until Go
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDRW         = 11,
    parameter int TIMEOUT       = 1000000,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_q,
    input  logic             rx_dv,
    output logic             rx_rd,
    output logic [7:0]       tx_d,
    output logic             tx_wr,
    input  logic             tx_thre,
    output logic [ADDRW-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    output logic             mem_re,
    input  logic [31:0]      mem_rdata,
    output logic             cpu_hold,
    output logic             busy
);

    state_t      state, state_n;
    logic [31:0] addr;
    logic [31:0] addr_inc;
    logic [15:0] len;
    logic [15:0] len_hdr;
    logic [7:0]  sum;
    logic [2:0]  hdr_cnt;
    logic        is_write, is_go;
    logic        rx_guard, tx_guard;
    logic        rx_take, tx_fire, to_en, expired, to_abort;

    // rx_rd is registered, so rx_dv is still high while it is asserted; block that cycle and the next
    assign rx_take  = (state inside {S_IDLE, S_HDR, S_WDATA, S_WSUM}) && rx_dv && !rx_rd && !rx_guard;
    assign tx_fire  = (state inside {S_RSEND, S_RSUM, S_RESP}) && tx_thre && !tx_guard;
    assign to_en    = state inside {S_HDR, S_WDATA, S_WSUM};
    assign to_abort = expired && !rx_take;
    assign tx_wr    = tx_fire;
    assign mem_re   = (state == S_RREQ);
    assign busy     = (state != S_IDLE);
    assign addr_inc = addr + 32'd1;
    assign len_hdr  = {rx_q, len[7:0]};

    uart_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_take),
        .en      (to_en),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (rx_take) state_n = (rx_q == CMD_W || rx_q == CMD_R) ? S_HDR : S_RESP;
            S_HDR: begin
                if (rx_take) begin
                    if (hdr_cnt == 3'd5) begin
                        if (len_hdr == 16'd0) state_n = is_write ? S_WSUM : S_RSUM;
                        else                  state_n = is_write ? S_WDATA : S_RREQ;
                    end
                end else if (expired) begin
                    state_n = S_RESP;
                end
            end
            S_WDATA: begin
                if (rx_take) begin
                    if (len == 16'd1) state_n = S_WSUM;
                end else if (expired) begin
                    state_n = S_RESP;
                end
            end
            S_WSUM:  if (rx_take || expired) state_n = S_RESP;
            S_RREQ:  state_n = S_RLAT;
            S_RLAT:  state_n = S_RSEND;
            S_RSEND: if (tx_fire) state_n = (len == 16'd1) ? S_RSUM : S_RREQ;
            S_RSUM:  if (tx_fire) state_n = S_IDLE;
            S_RESP:  if (tx_fire) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            len       <= '0;
            sum       <= '0;
            hdr_cnt   <= '0;
            is_write  <= 1'b0;
            is_go     <= 1'b0;
            rx_rd     <= 1'b0;
            rx_guard  <= 1'b0;
            tx_guard  <= 1'b0;
            tx_d      <= '0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            cpu_hold  <= HOLD_ON_RESET;
        end else begin
            state     <= state_n;
            rx_rd     <= rx_take;
            rx_guard  <= rx_rd;
            tx_guard  <= tx_fire;
            mem_wstrb <= '0;
            case (state)
                S_IDLE: if (rx_take) begin
                    sum      <= '0;
                    hdr_cnt  <= '0;
                    is_write <= (rx_q == CMD_W);
                    is_go    <= (rx_q == CMD_G);
                    tx_d     <= (rx_q == CMD_G) ? ACK : NAK;
                end
                S_HDR: if (rx_take) begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                    if (hdr_cnt < 3'd4)       addr[{hdr_cnt[1:0], 3'b000} +: 8] <= rx_q;
                    else if (hdr_cnt == 3'd4) len[7:0]  <= rx_q;
                    else                      len[15:8] <= rx_q;
                    if (hdr_cnt == 3'd5) begin
                        tx_d     <= sum;
                        mem_addr <= addr[ADDRW+1:2];
                    end
                end
                S_WDATA: if (rx_take) begin
                    mem_addr  <= addr[ADDRW+1:2];
                    mem_wdata <= {4{rx_q}};
                    mem_wstrb <= 4'b0001 << addr[1:0];
                    addr      <= addr_inc;
                    len       <= len - 16'd1;
                    sum       <= sum + rx_q;
                end
                S_WSUM: if (rx_take) tx_d <= (rx_q == sum) ? ACK : NAK;
                S_RLAT: tx_d <= mem_rdata[{addr[1:0], 3'b000} +: 8];
                S_RSEND: if (tx_fire) begin
                    sum      <= sum + tx_d;
                    addr     <= addr_inc;
                    len      <= len - 16'd1;
                    mem_addr <= addr_inc[ADDRW+1:2];
                    if (len == 16'd1) tx_d <= sum + tx_d;
                end
                S_RESP: if (tx_fire && is_go) cpu_hold <= 1'b0;
                default: ;
            endcase
            // Partial frames are not rolled back; the abort only answers NAK
            if (to_abort) tx_d <= NAK;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader with UART and RAM models
module tb_uart_loader;

    localparam int AW = 11;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_q;
    logic          rx_dv;
    logic          rx_rd;
    logic [7:0]    tx_d;
    logic          tx_wr;
    logic          tx_thre;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic          mem_re;
    logic [31:0]   mem_rdata;
    logic          cpu_hold;
    logic          busy;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [63:0] wr_log[$];
    int cyc = 0, tx_busy = 0, n_rxrd = 0, n_re = 0, n_thre_viol = 0, n_collide = 0, last_rx_cyc = 0;
    int n_total = 0, n_pass = 0, n_fail = 0;
    logic force_low;

    uart_loader #(.ADDRW(AW), .TIMEOUT(100), .HOLD_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_q      (rx_q),
        .rx_dv     (rx_dv),
        .rx_rd     (rx_rd),
        .tx_d      (tx_d),
        .tx_wr     (tx_wr),
        .tx_thre   (tx_thre),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_thre = !force_low && (tx_busy == 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_rdata <= ram[mem_addr];
        for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    always @(negedge clk) begin
        if (tx_wr) begin
            if (!tx_thre) n_thre_viol++;
            tx_log.push_back(tx_d);
            tx_cyc.push_back(cyc);
        end
        if (tx_busy > 0) tx_busy--;
        if (tx_wr) tx_busy = 3;
        if (rx_rd) begin
            n_rxrd++;
            last_rx_cyc = cyc;
        end
        if (mem_re) n_re++;
        if (mem_re && mem_wstrb != 4'd0) n_collide++;
        if (mem_wstrb != 4'd0) wr_log.push_back({17'b0, mem_addr, mem_wstrb, mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(posedge clk); #2;
        rx_q  = b;
        rx_dv = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_rd && k < 200);
        rx_dv = 1'b0;
        check("rx_rd", rx_rd, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (tx_log.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("tx_count", tx_log.size(), n);
        repeat (4) @(posedge clk);
    endtask

    task automatic clear_logs();
        @(posedge clk); #2;
        tx_log.delete();
        tx_cyc.delete();
        wr_log.delete();
        n_re = 0;
    endtask

    task automatic check_writes(input string tag);
        logic [7:0] wb [4];
        wb = '{8'h11, 8'h22, 8'h33, 8'h44};
        check({tag, "_nwr"}, wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check({tag, "_wr"}, wr_log[i], {17'b0, 11'd4, 4'(1 << i), {4{wb[i]}}});
    endtask

    initial begin
        logic [7:0] fr[$];
        int rx0, t0, d;
        reset = 1'b0;
        rx_dv = 1'b0;
        rx_q = 8'h00;
        force_low = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outs", {rx_rd, tx_wr, mem_re, busy, mem_wstrb}, 8'h00);
        check("rst_bus", {tx_d, mem_addr, mem_wdata}, 0);
        check("rst_hold", cpu_hold, 1'b1);
        reset = 1'b1;

        // good write: four lanes of word 4, checksum AA
        clear_logs();
        fr = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
        send_frame(fr);
        @(posedge clk);
        rx0 = n_rxrd;
        fr = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(fr);
        @(posedge clk);
        check("w_rx_rd_data", n_rxrd - rx0, 4);
        send_byte(8'hAA);
        wait_tx(1);
        check("w_ack", tx_log[0], 8'h06);
        check_writes("w1");
        check("w_ram", ram[4], 32'h44332211);
        check("w_hold", cpu_hold, 1'b1);

        // bad checksum still writes, answers NAK
        clear_logs();
        fr = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        send_frame(fr);
        wait_tx(1);
        check("wbad_nak", tx_log[0], 8'h15);
        check_writes("w2");

        // zero-length write
        clear_logs();
        fr = '{8'h57, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        wait_tx(1);
        check("w0_ack", tx_log[0], 8'h06);
        check("w0_nwr", wr_log.size(), 0);

        // read two bytes from 0x11 with transmitter held busy for 50 cycles
        clear_logs();
        force_low = 1'b1;
        fr = '{8'h52, 8'h11, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
        send_frame(fr);
        repeat (50) @(posedge clk);
        #2;
        check("r_held", tx_log.size(), 0);
        force_low = 1'b0;
        wait_tx(3);
        check("r_b0", tx_log[0], 8'h22);
        check("r_b1", tx_log[1], 8'h33);
        check("r_sum", tx_log[2], 8'h55);
        check("r_nre", n_re, 2);
        check("r_hold", cpu_hold, 1'b1);

        // Go, unknown command, second Go
        clear_logs();
        send_byte(8'h47);
        wait_tx(1);
        check("g_ack", tx_log[0], 8'h06);
        check("g_hold", cpu_hold, 1'b0);
        clear_logs();
        send_byte(8'h5A);
        wait_tx(1);
        check("u_nak", tx_log[0], 8'h15);
        check("u_hold", cpu_hold, 1'b0);
        clear_logs();
        send_byte(8'h47);
        wait_tx(1);
        check("g2_ack", tx_log[0], 8'h06);
        check("g2_hold", cpu_hold, 1'b0);

        // inter-byte timeout inside a header
        clear_logs();
        fr = '{8'h57, 8'h00};
        send_frame(fr);
        @(posedge clk);
        t0 = last_rx_cyc;
        wait_tx(1);
        check("to_nak", tx_log[0], 8'h15);
        d = tx_cyc[0] - t0;
        check("to_delay_ok", (d >= 100 && d <= 104), 1'b1);
        check("to_idle", busy, 1'b0);
        clear_logs();
        send_byte(8'h47);
        wait_tx(1);
        check("to_g_ack", tx_log[0], 8'h06);

        // asynchronous reset in the middle of a write data phase
        clear_logs();
        fr = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02};
        send_frame(fr);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mr_outs", {rx_rd, tx_wr, mem_re, busy, mem_wstrb}, 8'h00);
        check("mr_bus", {tx_d, mem_addr, mem_wdata}, 0);
        check("mr_hold", cpu_hold, 1'b1);
        check("mr_partial", ram[64][15:0], 16'h0201);
        @(posedge clk); #2;
        reset = 1'b1;
        clear_logs();
        send_byte(8'h47);
        wait_tx(1);
        check("mr_g_ack", tx_log[0], 8'h06);
        check("mr_g_hold", cpu_hold, 1'b0);

        check("thre_viol", n_thre_viol, 0);
        check("re_wstrb", n_collide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial bootloader/debug responder for the LaRVa SoC. It is the command-side counterpart of UART_CORE's byte interface.
- It consumes bytes from a UART receiver, decodes framed Write/Read/Go commands, and drives a RAM write/read port (ram32 protocol) as memory initiator.
- It returns ACK/NAK/data bytes through the same UART's transmitter.
- It holds the CPU in reset until a Go command is received.

Parameters:
- ADDRW, 11, word-address width of the RAM port (11 gives 8 KB).
- TIMEOUT, 1000000, maximum clk cycles between received bytes inside a frame before the frame is aborted.
- HOLD_ON_RESET, 1, reset value of cpu_hold.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_q  in  8  received byte from UART_CORE
- rx_dv  in  1  received byte valid
- rx_rd  out  1  one-cycle pulse: byte consumed, clears rx_dv
- tx_d  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_thre  in  1  transmitter holding register empty
- mem_addr  out  ADDRW  word address
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  write data
- mem_re  out  1  read enable; mem_rdata is valid on the following cycle
- mem_rdata  in  32  registered read data
- cpu_hold  out  1  1 holds the CPU in reset
- busy  out  1  1 while any state other than IDLE is active

Behaviour:
- Reset values: all outputs 0, except cpu_hold = HOLD_ON_RESET. State = IDLE.
- Frame format:
  - Write: cmd byte 'W' (0x57), then addr (4 bytes, LSB first), then len (2 bytes, LSB first), then len data bytes, then sum (8-bit sum of the data bytes, mod 256).
  - Read: 'R' (0x52), addr(4), len(2).
  - Go: 'G' (0x47) only.
  - len = 0 is legal and means zero data bytes.
- Responses:
  - W: ACK 0x06 if the checksum matches, else NAK 0x15.
  - R: len data bytes, then the sum byte.
  - G: ACK, then cpu_hold goes to 0 in the cycle after tx_wr.
  - Unknown cmd: NAK.
- RX handshake:
  - In any receiving state, when rx_dv = 1, latch rx_q and pulse rx_rd for exactly one cycle.
  - Ignore rx_dv for the cycle after rx_rd (guard cycle).
  - In IDLE, bytes are consumed the same way.
- TX handshake:
  - tx_wr is asserted for one cycle only when tx_thre = 1, with tx_d stable during that cycle.
  - The block then waits one guard cycle before sampling tx_thre again.
- States:
  - IDLE: wait for a cmd byte.
  - HDR: collect 6 bytes into addr[31:0] and len[15:0]; byte counter 0..5.
  - WDATA: per byte, for exactly one cycle: mem_addr = addr[ADDRW+1:2], mem_wdata = {4{byte}}, mem_wstrb = 1 << addr[1:0]. Then addr += 1, len -= 1 and sum += byte. Exit to WSUM when len = 0.
  - WSUM: compare the received byte with sum; select ACK or NAK.
  - RREQ: mem_re = 1 for one cycle.
  - RLAT: capture lane addr[1:0] of mem_rdata.
  - RSEND: transmit the byte, update sum, addr += 1, len -= 1. Go to RREQ while len ≠ 0, else RSUM.
  - RSUM: transmit sum.
  - RESP: transmit ACK/NAK, then return to IDLE (or release cpu_hold for G).
- Arithmetic:
  - addr wraps modulo 2^32. Only bits [ADDRW+1:0] reach the port, so the memory window wraps.
  - len and sum are unsigned, with wrap.
- Timeout:
  - The counter resets on every consumed byte and is active in HDR, WDATA and WSUM.
  - On reaching TIMEOUT: abort, send NAK, go to IDLE.
  - Bytes already written are not rolled back.
- Other rules:
  - mem_wstrb and mem_re are never asserted in the same cycle.
  - sum clears on every cmd byte.
  - A second 'G' while cpu_hold = 0 still returns ACK; cpu_hold stays 0.
- Reset mid-frame: the state machine returns to IDLE asynchronously and cpu_hold returns to HOLD_ON_RESET. Any partial RAM writes remain.

Decomposition:
- Shared package holds:
  - command codes CMD_W/CMD_R/CMD_G;
  - ACK/NAK byte constants;
  - state encoding enum.
- One natural sub-module: uart_loader_timeout, a loadable down-counter with a clear input and an expiry output.
- The command FSM remains in uart_loader.

Test Plan:
- Write: 57 10 00 00 00 04 00 11 22 33 44 AA -> wstrb 1,2,4,8 at word 4 with bytes 11/22/33/44; response 06; exactly 4 rx_rd per data phase.
- Bad checksum: same frame with sum 00 -> same 4 writes; response 15.
- Read: after the write above, send 52 11 00 00 00 02 00 -> TX 22 33 55; mem_re pulses 2 times; tx_wr never asserted while tx_thre = 0 (hold thre low for 50 cycles).
- Go: 47 with cpu_hold = 1 -> TX 06, then cpu_hold = 0. Unknown byte 5A -> TX 15, cpu_hold unchanged.
- Timeout (TIMEOUT = 100): send 57 00 and then nothing -> NAK 15 after 100 idle cycles. A following 47 frame is accepted normally.
- Reset: drop reset during WDATA -> all outputs 0 immediately, cpu_hold = 1, next frame decodes from IDLE.
